// File: rtl/aes_pkg.sv
// aes_pkg: shared AES types, FSM encoding and GF(2^8) multiply-by-constant helpers
package aes_pkg;
    typedef logic [7:0]   aes_byte_t;
    typedef logic [31:0]  aes_word_t;
    typedef logic [127:0] aes_state_t;
    localparam int AES_NB = 4;
    typedef enum logic [1:0] {IDLE, RUN, DONE} imc_state_e;
    function automatic aes_byte_t xtime(aes_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic aes_byte_t gm9(aes_byte_t b);
        return xtime(xtime(xtime(b))) ^ b;
    endfunction
    function automatic aes_byte_t gm11(aes_byte_t b);
        return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
    endfunction
    function automatic aes_byte_t gm13(aes_byte_t b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
    endfunction
    function automatic aes_byte_t gm14(aes_byte_t b);
        return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
    endfunction
endpackage

// File: rtl/inv_mix_column_word.sv
// inv_mix_column_word: combinational InvMixColumns of a single 32-bit column
module inv_mix_column_word
    import aes_pkg::*;
(
    input  aes_word_t col_i,
    output aes_word_t col_o
);
    aes_byte_t a0, a1, a2, a3;
    assign {a0, a1, a2, a3} = col_i;
    assign col_o = {gm14(a0) ^ gm11(a1) ^ gm13(a2) ^ gm9(a3),
                    gm9(a0)  ^ gm14(a1) ^ gm11(a2) ^ gm13(a3),
                    gm13(a0) ^ gm9(a1)  ^ gm14(a2) ^ gm11(a3),
                    gm11(a0) ^ gm13(a1) ^ gm9(a2)  ^ gm14(a3)};
endmodule

// File: rtl/inv_mix_columns_iter.sv
// inv_mix_columns_iter: iterative InvMixColumns, COLS_PER_CYCLE columns per clock, valid/ready in and out
module inv_mix_columns_iter
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  aes_state_t in_state,
    output logic       out_valid,
    input  logic       out_ready,
    output aes_state_t out_state,
    output logic       busy
);
    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
        $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end
    localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST = 2'(AES_NB - COLS_PER_CYCLE);
    imc_state_e fsm_q, fsm_d;
    logic [1:0] col_cnt_q, col_cnt_d;
    aes_state_t state_q, state_d;
    aes_word_t  cols [AES_NB];
    aes_word_t  cols_d [AES_NB];
    aes_word_t  xf [COLS_PER_CYCLE];
    logic [1:0] idx [COLS_PER_CYCLE];
    logic       take;
    assign cols = '{state_q[127:96], state_q[95:64], state_q[63:32], state_q[31:0]};
    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
        assign idx[k] = col_cnt_q + 2'(k);
        inv_mix_column_word u_word (.col_i(cols[idx[k]]), .col_o(xf[k]));
    end
    assign in_ready  = !reset && (fsm_q == IDLE || (fsm_q == DONE && out_ready));
    assign take      = in_valid && in_ready;
    assign out_valid = fsm_q == DONE;
    assign busy      = fsm_q != IDLE;
    assign out_state = state_q;
    assign state_d   = take ? in_state : {cols_d[0], cols_d[1], cols_d[2], cols_d[3]};
    // next state: transform the selected columns in place while running, capture on accept
    always_comb begin
        fsm_d     = fsm_q;
        col_cnt_d = col_cnt_q;
        cols_d    = cols;
        if (fsm_q == RUN) begin
            for (int k = 0; k < COLS_PER_CYCLE; k++) cols_d[idx[k]] = xf[k];
            col_cnt_d = col_cnt_q + STEP;
            fsm_d     = col_cnt_q == LAST ? DONE : RUN;
        end else if (fsm_q == DONE && out_ready && !in_valid) begin
            fsm_d = IDLE;
        end
        if (take) begin
            fsm_d     = RUN;
            col_cnt_d = '0;
        end
    end
    // all engine state registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q     <= IDLE;
            col_cnt_q <= '0;
            state_q   <= '0;
        end else begin
            fsm_q     <= fsm_d;
            col_cnt_q <= col_cnt_d;
            state_q   <= state_d;
        end
    end
endmodule
